// File: rtl/bp_me_mem_responder_pkg.sv
// Shared types, message layout and size/mask helpers for the memory-side responder.
package bp_me_mem_responder_pkg;

  localparam int paddr_width_p     = 40;
  localparam int cce_block_width_p = 512;
  localparam int dword_width_p     = 64;
  localparam int lce_id_width_p    = 4;
  localparam int lce_assoc_p       = 8;

  localparam int dword_bytes_lp     = dword_width_p / 8;
  localparam int lg_dword_bytes_lp  = $clog2(dword_bytes_lp);
  localparam int lg_dword_width_lp  = $clog2(dword_width_p);
  localparam int block_beats_lp     = cce_block_width_p / dword_width_p;
  localparam int lg_block_beats_lp  = $clog2(block_beats_lp);
  localparam int beat_cnt_width_lp  = lg_block_beats_lp + 1;

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'd0,
    e_mem_msg_wr    = 4'd1,
    e_mem_msg_uc_rd = 4'd2,
    e_mem_msg_uc_wr = 4'd3
  } bp_mem_msg_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1  = 3'd0,
    e_mem_msg_size_2  = 3'd1,
    e_mem_msg_size_4  = 3'd2,
    e_mem_msg_size_8  = 3'd3,
    e_mem_msg_size_16 = 3'd4,
    e_mem_msg_size_32 = 3'd5,
    e_mem_msg_size_64 = 3'd6
  } bp_mem_msg_size_e;

  typedef enum logic [2:0] {
    e_reset, e_ready, e_wait, e_access, e_resp
  } bp_resp_state_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0]      lce_id;
    logic [$clog2(lce_assoc_p)-1:0] way_id;
  } bp_mem_payload_s;

  // msg_type is kept as raw bits so unlisted encodings survive the round trip.
  typedef struct packed {
    logic [3:0]               msg_type;
    logic [2:0]               size;
    logic [paddr_width_p-1:0] addr;
    bp_mem_payload_s          payload;
  } bp_mem_msg_header_s;

  typedef struct packed {
    bp_mem_msg_header_s             header;
    logic [cce_block_width_p-1:0]   data;
  } bp_mem_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_mem_msg_s);

  function automatic logic [beat_cnt_width_lp-1:0] beat_count(input logic [2:0] size);
    if (size <= 3'(lg_dword_bytes_lp)) return beat_cnt_width_lp'(1);
    if (size >= 3'(lg_dword_bytes_lp + lg_block_beats_lp)) return beat_cnt_width_lp'(block_beats_lp);
    return beat_cnt_width_lp'(1) << (size - 3'(lg_dword_bytes_lp));
  endfunction

  function automatic logic [2:0] lane_offset(input logic [2:0] size, input logic [2:0] off);
    return off & ~3'((1 << size) - 1);
  endfunction

  function automatic logic [dword_bytes_lp-1:0] byte_mask(input logic [2:0] size, input logic [2:0] off);
    logic [dword_bytes_lp-1:0] m;
    if (size >= 3'(lg_dword_bytes_lp)) return '1;
    m = dword_bytes_lp'((1 << (1 << size)) - 1);
    return m << lane_offset(size, off);
  endfunction

endpackage

// File: rtl/bp_me_mem_responder_if.sv
// mem_cmd / mem_resp channel between a cache slice (master) and the responder (slave).
interface bp_me_mem_responder_if;
  import bp_me_mem_responder_pkg::*;

  // cmd: transfer when mem_cmd_v_i && mem_cmd_ready_o on a rising edge; ready never looks at valid.
  // resp: mem_resp_o is held stable while mem_resp_v_o is high; yumi is only legal with valid high.
  bp_mem_msg_s mem_cmd_i;
  logic        mem_cmd_v_i;
  logic        mem_cmd_ready_o;
  bp_mem_msg_s mem_resp_o;
  logic        mem_resp_v_o;
  logic        mem_resp_yumi_i;

  modport master (
    output mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i,
    input  mem_cmd_ready_o, mem_resp_o, mem_resp_v_o
  );

  modport slave (
    input  mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i,
    output mem_cmd_ready_o, mem_resp_o, mem_resp_v_o
  );
endinterface

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write enables; read data lands one cycle later.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int width_p = 64,
  parameter int els_p   = 4096,
  localparam int lg_els_lp = $clog2(els_p),
  localparam int bytes_lp  = width_p / 8
) (
  input  logic                 i_clk,
  input  logic                 i_v,
  input  logic                 i_w,
  input  logic [lg_els_lp-1:0] i_addr,
  input  logic [width_p-1:0]   i_data,
  input  logic [bytes_lp-1:0]  i_mask,
  output logic [width_p-1:0]   o_data
);

  logic [width_p-1:0] r_mem [els_p];
  logic [width_p-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_v && i_w) begin
      for (int b = 0; b < bytes_lp; b++) begin
        if (i_mask[b]) r_mem[i_addr][b*8 +: 8] <= i_data[b*8 +: 8];
      end
    end
    if (i_v && !i_w) r_data <= r_mem[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/bp_me_mem_responder.sv
// Memory endpoint: accepts one mem_cmd, runs it against local RAM one dword per beat, returns mem_resp.
module bp_me_mem_responder
  import bp_me_mem_responder_pkg::*;
#(
  parameter int mem_els_p     = 4096,
  parameter int mem_latency_p = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  bp_me_mem_responder_if.slave mem,
  output bp_resp_state_e       o_dbg_state
);

  localparam int lg_els_lp        = $clog2(mem_els_p);
  localparam int lat_cnt_width_lp = (mem_latency_p > 0) ? $clog2(mem_latency_p + 1) : 1;

  bp_resp_state_e                 r_state, w_next_state;
  bp_mem_msg_s                    r_cmd;
  logic [cce_block_width_p-1:0]   r_rdata;
  logic [beat_cnt_width_lp-1:0]   r_beat;
  logic [lat_cnt_width_lp-1:0]    r_lat;

  logic [beat_cnt_width_lp-1:0]   w_n;
  logic                           w_is_rd, w_is_wr, w_sub, w_done, w_accept, w_capture;
  logic [2:0]                     w_lane;
  logic [lg_block_beats_lp-1:0]   w_beat_idx, w_cap_idx;
  logic [lg_els_lp-1:0]           w_base;
  logic [dword_bytes_lp-1:0]      w_sub_mask;
  logic [dword_width_p-1:0]       w_sub_bits, w_rd_dword;

  logic                           w_ram_v, w_ram_w;
  logic [lg_els_lp-1:0]           w_ram_addr;
  logic [dword_width_p-1:0]       w_ram_wdata, w_ram_rdata;
  logic [dword_bytes_lp-1:0]      w_ram_mask;

  assign w_n        = beat_count(r_cmd.header.size);
  assign w_is_rd    = (r_cmd.header.msg_type == e_mem_msg_rd) || (r_cmd.header.msg_type == e_mem_msg_uc_rd);
  assign w_is_wr    = (r_cmd.header.msg_type == e_mem_msg_wr) || (r_cmd.header.msg_type == e_mem_msg_uc_wr);
  assign w_sub      = r_cmd.header.size < 3'(lg_dword_bytes_lp);
  assign w_lane     = lane_offset(r_cmd.header.size, r_cmd.header.addr[2:0]);
  assign w_beat_idx = r_beat[lg_block_beats_lp-1:0];
  assign w_cap_idx  = w_beat_idx - lg_block_beats_lp'(1);
  // Reads stay in e_access one extra beat slot to collect the final sync-read dword.
  assign w_done     = w_is_rd ? (r_beat == w_n) : (r_beat == w_n - beat_cnt_width_lp'(1));
  assign w_accept   = mem.mem_cmd_ready_o && mem.mem_cmd_v_i;

  assign w_base     = lg_els_lp'(r_cmd.header.addr >> lg_dword_bytes_lp)
                    & ~lg_els_lp'(w_n - beat_cnt_width_lp'(1));
  assign w_ram_addr = w_base + lg_els_lp'(r_beat);
  assign w_ram_w    = !w_is_rd;
  assign w_ram_mask = w_is_wr ? byte_mask(r_cmd.header.size, r_cmd.header.addr[2:0]) : '0;
  assign w_ram_wdata = w_sub ? (r_cmd.data[dword_width_p-1:0] << {w_lane, 3'b000})
                             : r_cmd.data[{w_beat_idx, {lg_dword_width_lp{1'b0}}} +: dword_width_p];

  assign w_sub_mask = byte_mask(r_cmd.header.size, 3'b000);
  always_comb begin
    w_sub_bits = '0;
    for (int b = 0; b < dword_bytes_lp; b++) w_sub_bits[b*8 +: 8] = {8{w_sub_mask[b]}};
  end
  assign w_rd_dword = w_sub ? ((w_ram_rdata >> {w_lane, 3'b000}) & w_sub_bits) : w_ram_rdata;

  always_ff @(posedge clk_i) begin
    if (!reset_i) r_state <= e_reset;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      e_reset:  w_next_state = e_ready;
      e_ready:  if (mem.mem_cmd_v_i) w_next_state = (mem_latency_p == 0) ? e_access : e_wait;
      e_wait:   if (r_lat == lat_cnt_width_lp'(mem_latency_p - 1)) w_next_state = e_access;
      e_access: if (w_done) w_next_state = e_resp;
      e_resp:   if (mem.mem_resp_yumi_i) w_next_state = e_ready;
      default:  w_next_state = e_reset;
    endcase
  end

  always_comb begin
    mem.mem_cmd_ready_o = 1'b0;
    mem.mem_resp_v_o    = 1'b0;
    w_ram_v             = 1'b0;
    w_capture           = 1'b0;
    unique case (r_state)
      e_ready:  mem.mem_cmd_ready_o = 1'b1;
      e_access: begin
        w_ram_v   = r_beat < w_n;
        w_capture = w_is_rd && (r_beat != '0);
      end
      e_resp:   mem.mem_resp_v_o = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_cmd   <= '0;
      r_rdata <= '0;
      r_beat  <= '0;
      r_lat   <= '0;
    end else begin
      if (w_accept) begin
        r_cmd   <= mem.mem_cmd_i;
        r_rdata <= '0;
        r_beat  <= '0;
        r_lat   <= '0;
      end
      if (r_state == e_wait)   r_lat  <= r_lat + lat_cnt_width_lp'(1);
      if (r_state == e_access) r_beat <= r_beat + beat_cnt_width_lp'(1);
      if (w_capture) r_rdata[{w_cap_idx, {lg_dword_width_lp{1'b0}}} +: dword_width_p] <= w_rd_dword;
    end
  end

  assign mem.mem_resp_o.header = r_cmd.header;
  assign mem.mem_resp_o.data   = r_rdata;
  assign o_dbg_state           = r_state;

  bsg_mem_1rw_sync_mask_write_byte #(
    .width_p (dword_width_p),
    .els_p   (mem_els_p)
  ) u_ram (
    .i_clk  (clk_i),
    .i_v    (w_ram_v),
    .i_w    (w_ram_w),
    .i_addr (w_ram_addr),
    .i_data (w_ram_wdata),
    .i_mask (w_ram_mask),
    .o_data (w_ram_rdata)
  );

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_i)
    mem.mem_resp_yumi_i |-> mem.mem_resp_v_o);

endmodule

// File: tb/tb_bp_me_mem_responder.sv
// Bench for bp_me_mem_responder: directed scenarios then random traffic against a byte-level memory model.
module tb_bp_me_mem_responder;
  import bp_me_mem_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n, sel, cmd_v, yumi;
  bp_mem_msg_s    cmd;
  bp_resp_state_e dbg0, dbg1;
  int             n_cmp, n_fail;

  bp_me_mem_responder_if if0();
  bp_me_mem_responder_if if1();

  assign if0.mem_cmd_i       = cmd;
  assign if1.mem_cmd_i       = cmd;
  assign if0.mem_cmd_v_i     = cmd_v && !sel;
  assign if1.mem_cmd_v_i     = cmd_v && sel;
  assign if0.mem_resp_yumi_i = yumi && !sel;
  assign if1.mem_resp_yumi_i = yumi && sel;

  logic        obs_ready, obs_resp_v;
  bp_mem_msg_s obs_resp;
  assign obs_ready  = sel ? if1.mem_cmd_ready_o : if0.mem_cmd_ready_o;
  assign obs_resp_v = sel ? if1.mem_resp_v_o    : if0.mem_resp_v_o;
  assign obs_resp   = sel ? if1.mem_resp_o      : if0.mem_resp_o;

  bp_me_mem_responder #(.mem_els_p(4096), .mem_latency_p(0)) dut0 (
    .clk_i(clk), .reset_i(reset_n), .mem(if0), .o_dbg_state(dbg0));
  bp_me_mem_responder #(.mem_els_p(16), .mem_latency_p(5)) dut1 (
    .clk_i(clk), .reset_i(reset_n), .mem(if1), .o_dbg_state(dbg1));

  // Byte-addressed reference memory per instance: [instance][dword index][byte lane].
  logic [7:0] mdl [2][4096][8];

  task automatic chk(input string tag, input logic [599:0] got, input logic [599:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bp_mem_msg_s mk(input logic [3:0] t, input logic [2:0] sz,
                                     input logic [39:0] a, input logic [511:0] d);
    bp_mem_msg_s m;
    m.header.msg_type       = t;
    m.header.size           = sz;
    m.header.addr           = a;
    m.header.payload.lce_id = 4'($urandom);
    m.header.payload.way_id = 3'($urandom);
    m.data                  = d;
    return m;
  endfunction

  task automatic model_txn(input bp_mem_msg_s c, output logic [511:0] exp_data, output int exp_lat);
    int  els, nbytes, n, off, dw, base, idx, span;
    logic is_rd, is_wr;
    els    = sel ? 16 : 4096;
    nbytes = 1 << c.header.size;
    n      = (nbytes <= 8) ? 1 : nbytes / 8;
    span   = (nbytes < 8) ? nbytes : 8;
    off    = (nbytes < 8) ? (int'(c.header.addr[2:0]) / nbytes) * nbytes : 0;
    dw     = int'((c.header.addr >> 3) % 40'(els));
    base   = dw - (dw % n);
    is_rd  = (c.header.msg_type == e_mem_msg_rd) || (c.header.msg_type == e_mem_msg_uc_rd);
    is_wr  = (c.header.msg_type == e_mem_msg_wr) || (c.header.msg_type == e_mem_msg_uc_wr);
    exp_lat  = (is_rd ? 2 : 1) + (sel ? 5 : 0) + n;
    exp_data = '0;
    for (int i = 0; i < n; i++) begin
      idx = (base + i) % els;
      for (int b = 0; b < span; b++) begin
        if (is_rd) exp_data[i*64 + b*8 +: 8] = mdl[sel][idx][off + b];
        if (is_wr) mdl[sel][idx][off + b] = c.data[i*64 + b*8 +: 8];
      end
    end
  endtask

  task automatic do_txn(input bp_mem_msg_s c, input int hold, output logic [511:0] got_data);
    logic [511:0] exp_data;
    bp_mem_msg_s  exp_resp;
    int           exp_lat, waited, lat;
    got_data = '0;
    model_txn(c, exp_data, exp_lat);
    exp_resp.header = c.header;
    exp_resp.data   = exp_data;
    cmd = c; cmd_v = 1'b1;
    waited = 0;
    while (!obs_ready && waited < 50) begin @(negedge clk); waited++; end
    if (!obs_ready) begin
      cmd_v = 1'b0;
      chk("accept_timeout", 600'(obs_ready), 600'(1'b1));
      return;
    end
    @(negedge clk); cmd_v = 1'b0; lat = 1;
    while (!obs_resp_v && lat < 300) begin @(negedge clk); lat++; end
    chk("resp_latency", 600'(lat), 600'(exp_lat));
    if (!obs_resp_v) return;
    chk("resp_msg", 600'(obs_resp), 600'(exp_resp));
    got_data = obs_resp.data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_msg", 600'(obs_resp), 600'(exp_resp));
      chk("hold_flags", 600'({obs_ready, obs_resp_v}), 600'(2'b01));
    end
    yumi = 1'b1;
    @(negedge clk); yumi = 1'b0;
    chk("ready_after_yumi", 600'({obs_ready, obs_resp_v}), 600'(2'b10));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  logic [511:0] got, d;
  logic [63:0]  v;
  int           waited;
  logic [3:0]   t;

  initial begin
    n_cmp = 0; n_fail = 0;
    reset_n = 1'b0; sel = 1'b0; cmd_v = 1'b0; yumi = 1'b0; cmd = '0;
    repeat (3) @(negedge clk);
    chk("reset_flags0", 600'({if0.mem_cmd_ready_o, if0.mem_resp_v_o}), 600'(2'b00));
    chk("reset_flags1", 600'({if1.mem_cmd_ready_o, if1.mem_resp_v_o}), 600'(2'b00));
    chk("reset_resp0", 600'(if0.mem_resp_o), 600'(0));
    chk("reset_resp1", 600'(if1.mem_resp_o), 600'(0));
    chk("reset_state", 600'(dbg0), 600'(e_reset));
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 600'({if0.mem_cmd_ready_o, if1.mem_cmd_ready_o}), 600'(2'b11));

    // Block write then read back.
    for (int i = 0; i < 8; i++) d[i*64 +: 64] = 64'(i);
    do_txn(mk(e_mem_msg_wr, e_mem_msg_size_64, 40'h80, d), 0, got);
    do_txn(mk(e_mem_msg_rd, e_mem_msg_size_64, 40'h80, rand512()), 0, got);
    chk("blk_rd_data", 600'(got), 600'(d));

    // Single-byte write into a preset dword.
    do_txn(mk(e_mem_msg_uc_wr, e_mem_msg_size_8, 40'h1000, {rand512() >> 64, 64'h1122334455667788}), 0, got);
    do_txn(mk(e_mem_msg_uc_wr, e_mem_msg_size_1, 40'h1003, {rand512() >> 8, 8'hAB}), 0, got);
    do_txn(mk(e_mem_msg_uc_rd, e_mem_msg_size_8, 40'h1000, rand512()), 0, got);
    chk("subdword_rd", 600'(got), 600'(64'h11223344AB667788));

    // Wrap-around and latency on the 16-entry, 5-cycle instance.
    sel = 1'b1;
    v = {$urandom, $urandom};
    do_txn(mk(e_mem_msg_wr, e_mem_msg_size_8, 40'h80, {rand512() >> 64, v}), 0, got);
    do_txn(mk(e_mem_msg_rd, e_mem_msg_size_8, 40'h0, rand512()), 0, got);
    chk("wrap_rd", 600'(got), 600'(v));

    // Backpressure, then a command right behind the yumi.
    sel = 1'b0;
    do_txn(mk(e_mem_msg_rd, e_mem_msg_size_64, 40'h80, rand512()), 20, got);
    chk("bp_rd_data", 600'(got), 600'(d));
    do_txn(mk(e_mem_msg_uc_rd, e_mem_msg_size_4, 40'h1004, rand512()), 0, got);
    chk("bp_next_rd", 600'(got), 600'(32'h11223344));

    // Reset during beat 3 of a block read.
    cmd = mk(e_mem_msg_rd, e_mem_msg_size_64, 40'h80, rand512()); cmd_v = 1'b1;
    waited = 0;
    while (!obs_ready && waited < 50) begin @(negedge clk); waited++; end
    chk("midrst_accept", 600'(obs_ready), 600'(1'b1));
    @(negedge clk); cmd_v = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_flags", 600'({obs_ready, obs_resp_v}), 600'(2'b00));
    @(negedge clk);
    chk("midrst_resp", 600'(obs_resp), 600'(0));
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 600'({obs_ready, obs_resp_v}), 600'(2'b10));
    do_txn(mk(e_mem_msg_rd, e_mem_msg_size_64, 40'h80, rand512()), 1, got);
    chk("post_rst_rd", 600'(got), 600'(d));

    // Preload a region in each instance, then random traffic over it.
    for (int b = 0; b < 16; b++) do_txn(mk(e_mem_msg_wr, e_mem_msg_size_64, 40'(b * 64), rand512()), 0, got);
    sel = 1'b1;
    do_txn(mk(e_mem_msg_wr, e_mem_msg_size_64, 40'h0, rand512()), 0, got);
    do_txn(mk(e_mem_msg_wr, e_mem_msg_size_64, 40'h40, rand512()), 0, got);
    for (int k = 0; k < 60; k++) begin
      sel = 1'($urandom_range(0, 1));
      t = ($urandom_range(0, 9) < 9) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
      do_txn(mk(t, 3'($urandom_range(0, 6)),
                sel ? {8'($urandom), 32'($urandom)} : 40'($urandom_range(0, 1023)),
                rand512()),
             $urandom_range(0, 3), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
